// File: rtl/sand_frame_sequencer_pkg.sv
// Shared types and default grid geometry for the sand frame sequencer slice.
// The package is named sand_pkg so the sequencer, copier and future sand blocks share one namespace.
package sand_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_COMPUTE,
        SEQ_COPY,
        SEQ_HOLD
    } seq_state_t;

    localparam int DEFAULT_COLUMNS    = 640;
    localparam int DEFAULT_ROWS       = 480;
    localparam int DEFAULT_DATA_WIDTH = 1;
    localparam int DEFAULT_TICK_WIDTH = 27;

endpackage

// File: rtl/sand_frame_sequencer_if.sv
// Memory-side bundle of the sequencer: simulation RAM read port and VRAM write port.
// The master side belongs to the sequencer; the slave side belongs to the memories.
interface sand_frame_sequencer_if #(
    parameter int ADDR_WIDTH = 19,
    parameter int DATA_WIDTH = 1
);

    logic [ADDR_WIDTH-1:0] ram_rd_address_o;
    logic [DATA_WIDTH-1:0] ram_rd_data_i;
    logic [ADDR_WIDTH-1:0] vram_wr_address_o;
    logic [DATA_WIDTH-1:0] vram_wr_data_o;
    logic                  vram_wr_en_o;

    modport master (
        output ram_rd_address_o,
        input  ram_rd_data_i,
        output vram_wr_address_o,
        output vram_wr_data_o,
        output vram_wr_en_o
    );

    modport slave (
        input  ram_rd_address_o,
        output ram_rd_data_i,
        input  vram_wr_address_o,
        input  vram_wr_data_o,
        input  vram_wr_en_o
    );

endinterface

// File: rtl/frame_copier.sv
// Streams cells 0..CELL_COUNT-1 from the simulation RAM into VRAM while active_i is high.
// Reads are issued back to back; each write trails its read by the RAM's one-cycle latency.
module frame_copier #(
    parameter int CELL_COUNT = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  active_i,
    output logic [ADDR_WIDTH-1:0] rd_address_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic [ADDR_WIDTH-1:0] wr_address_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_en_o,
    output logic                  done_o
);

    // One extra counter bit lets the count reach CELL_COUNT itself, marking the drain cycle.
    localparam logic [ADDR_WIDTH:0] LAST_COUNT = (ADDR_WIDTH + 1)'(CELL_COUNT);

    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH-1:0] wr_address_q;
    logic                  wr_en_q;
    logic                  rd_valid;

    assign rd_valid     = active_i && (count_q != LAST_COUNT);
    assign done_o       = active_i && (count_q == LAST_COUNT);
    assign rd_address_o = rd_valid ? count_q[ADDR_WIDTH-1:0] : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q      <= '0;
            wr_address_q <= '0;
            wr_en_q      <= 1'b0;
        end else begin
            count_q      <= rd_valid ? count_q + (ADDR_WIDTH + 1)'(1) : '0;
            wr_address_q <= rd_address_o;
            wr_en_q      <= rd_valid;
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_address_o = wr_address_q;
    assign wr_data_o    = wr_en_q ? rd_data_i : '0;

endmodule

// File: rtl/sand_frame_sequencer.sv
// Paces sand generations: start the compute engine, copy the grid to VRAM, then hold for period_i cycles.
// Defining SAND_FRAME_COUNTER_EN adds frame_count_o, a 16-bit wrapping count of completed generations.
module sand_frame_sequencer
    import sand_pkg::*;
#(
    parameter int ACTIVE_COLUMNS = DEFAULT_COLUMNS,
    parameter int ACTIVE_ROWS    = DEFAULT_ROWS,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TICK_WIDTH     = DEFAULT_TICK_WIDTH,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [TICK_WIDTH-1:0] period_i,
    input  logic                  run_i,
    input  logic                  step_i,
    input  logic                  draw_en_i,
    output logic                  draw_en_o,
    output logic                  eng_start_o,
    input  logic                  eng_done_i,
    sand_frame_sequencer_if.master mem,
    output logic                  busy_o
`ifdef SAND_FRAME_COUNTER_EN
    ,
    output logic [15:0]           frame_count_o
`endif
);

    seq_state_t            state_q;
    logic [TICK_WIDTH-1:0] hold_count_q;
    logic [TICK_WIDTH-1:0] hold_last;
    logic                  copy_active;
    logic                  copy_done;

    // A zero period holds for one cycle; >= lets a shortened period end HOLD at once.
    assign hold_last   = (period_i == '0) ? '0 : period_i - TICK_WIDTH'(1);
    assign copy_active = (state_q == SEQ_COPY);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= SEQ_IDLE;
            eng_start_o  <= 1'b0;
            busy_o       <= 1'b0;
            hold_count_q <= '0;
        end else begin
            eng_start_o <= 1'b0;
            case (state_q)
                SEQ_IDLE: begin
                    if (run_i || step_i) begin
                        state_q     <= SEQ_COMPUTE;
                        eng_start_o <= 1'b1;
                        busy_o      <= 1'b1;
                    end
                end
                SEQ_COMPUTE: begin
                    // eng_start_o is still high in the start cycle, so a stale done is ignored there.
                    if (!eng_start_o && eng_done_i) begin
                        state_q <= SEQ_COPY;
                    end
                end
                SEQ_COPY: begin
                    if (copy_done) begin
                        state_q      <= SEQ_HOLD;
                        busy_o       <= 1'b0;
                        hold_count_q <= '0;
                    end
                end
                SEQ_HOLD: begin
                    if (hold_count_q >= hold_last) begin
                        state_q      <= SEQ_IDLE;
                        hold_count_q <= '0;
                    end else begin
                        hold_count_q <= hold_count_q + TICK_WIDTH'(1);
                    end
                end
                default: state_q <= SEQ_IDLE;
            endcase
        end
    end

    // Drawing is only safe while nothing is streaming into VRAM.
    assign draw_en_o = draw_en_i && !reset_i &&
                       ((state_q == SEQ_IDLE) || (state_q == SEQ_HOLD));

`ifdef SAND_FRAME_COUNTER_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            frame_count_o <= 16'd0;
        end else if (copy_active && copy_done) begin
            frame_count_o <= frame_count_o + 16'd1;
        end
    end
`endif

    frame_copier #(
        .CELL_COUNT (ACTIVE_COLUMNS * ACTIVE_ROWS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_copier (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .active_i     (copy_active),
        .rd_address_o (mem.ram_rd_address_o),
        .rd_data_i    (mem.ram_rd_data_i),
        .wr_address_o (mem.vram_wr_address_o),
        .wr_data_o    (mem.vram_wr_data_o),
        .wr_en_o      (mem.vram_wr_en_o),
        .done_o       (copy_done)
    );

endmodule

// File: tb/tb_sand_frame_sequencer.sv
// Directed bench for sand_frame_sequencer on a 4x2 grid with a 4-bit RAM and a 3-cycle engine model.
// Define SAND_FRAME_COUNTER_EN to also exercise frame_count_o.
module tb_sand_frame_sequencer;

    localparam int COLS  = 4;
    localparam int ROWS  = 2;
    localparam int CELLS = 8;
    localparam int DW    = 4;
    localparam int AW    = 3;
    localparam int TW    = 8;

    // Hand-computed contents of the preloaded RAM: (3*a + 5) mod 16.
    localparam logic [DW-1:0] EXP_DATA [CELLS] = '{4'd5, 4'd8, 4'd11, 4'd14, 4'd1, 4'd4, 4'd7, 4'd10};

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [TW-1:0] period_i = '0;
    logic          run_i = 1'b0;
    logic          step_i = 1'b0;
    logic          draw_en_i = 1'b0;
    logic          draw_en_o;
    logic          eng_start_o;
    logic          eng_done_i = 1'b0;
    logic          busy_o;
`ifdef SAND_FRAME_COUNTER_EN
    logic [15:0]   frame_count_o;
`endif

    sand_frame_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    sand_frame_sequencer #(
        .ACTIVE_COLUMNS (COLS),
        .ACTIVE_ROWS    (ROWS),
        .DATA_WIDTH     (DW),
        .TICK_WIDTH     (TW),
        .ADDR_WIDTH     (AW)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .period_i    (period_i),
        .run_i       (run_i),
        .step_i      (step_i),
        .draw_en_i   (draw_en_i),
        .draw_en_o   (draw_en_o),
        .eng_start_o (eng_start_o),
        .eng_done_i  (eng_done_i),
        .mem         (mem_if.master),
        .busy_o      (busy_o)
`ifdef SAND_FRAME_COUNTER_EN
        ,
        .frame_count_o (frame_count_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // RAM with one-cycle read latency.
    logic [DW-1:0] ram [CELLS];
    always @(posedge clk_i) mem_if.ram_rd_data_i <= ram[mem_if.ram_rd_address_o];

    // Engine answers done in the third cycle after the start cycle, or always when eng_always is set.
    int   eng_wait = 0;
    logic eng_always = 1'b0;
    always @(posedge clk_i) begin
        #1;
        if (reset_i) eng_wait = 0;
        else if (eng_start_o) eng_wait = 1;
        else if (eng_wait != 0 && eng_wait < 4) eng_wait = eng_wait + 1;
        else eng_wait = 0;
        eng_done_i = eng_always || (eng_wait == 4);
    end

    int test_count = 0;
    int fail_count = 0;
    int cycle_no = 0;
    int busy_cycles;
    int draw_low_cycles;
    int start_cycles[$];
    int wr_cycles[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        test_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic run, input logic step, input logic [TW-1:0] period, input logic draw);
        run_i     = run;
        step_i    = step;
        period_i  = period;
        draw_en_i = draw;
    endtask

    task automatic clearLog();
        busy_cycles     = 0;
        draw_low_cycles = 0;
        start_cycles.delete();
        wr_cycles.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic stepCycle();
        @(negedge clk_i);
        cycle_no++;
        if (mem_if.vram_wr_en_o) begin
            wr_cycles.push_back(cycle_no);
            wr_addr_q.push_back(mem_if.vram_wr_address_o);
            wr_data_q.push_back(mem_if.vram_wr_data_o);
        end
        if (eng_start_o) start_cycles.push_back(cycle_no);
        if (busy_o) busy_cycles++;
        if (!draw_en_o) draw_low_cycles++;
    endtask

    task automatic applyReset();
        reset_i = 1'b1;
        eng_always = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, draw_en_i);
        stepCycle();
        stepCycle();
        reset_i = 1'b0;
        clearLog();
    endtask

    task automatic runUntilStarts(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (start_cycles.size() < n && k < budget) begin
            stepCycle();
            k++;
        end
        checkOutput(tag, 32'(start_cycles.size()), 32'(n));
    endtask

    task automatic runUntilWrites(input int n, input int budget);
        int k;
        k = 0;
        while (wr_addr_q.size() < n && k < budget) begin
            stepCycle();
            k++;
        end
    endtask

    task automatic checkWrites(input string tag);
        checkOutput({tag, "_wr_count"}, 32'(wr_addr_q.size()), 32'(CELLS));
        for (int i = 0; i < CELLS && i < wr_addr_q.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[i]), 32'(i));
            checkOutput($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]), 32'(EXP_DATA[i]));
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({draw_en_o, eng_start_o, busy_o, mem_if.vram_wr_en_o,
                    mem_if.vram_wr_address_o, mem_if.vram_wr_data_o, mem_if.ram_rd_address_o});
    endfunction

    initial begin
        for (int i = 0; i < CELLS; i++) ram[i] = DW'(i * 3 + 5);

        // Reset holds every output low even with a draw request pending.
        draw_en_i = 1'b1;
        applyReset();
        reset_i = 1'b1;
        stepCycle();
        checkOutput("reset_outputs", allOutputs(), 32'd0);
        reset_i = 1'b0;
        stepCycle();
        checkOutput("idle_draw", 32'(draw_en_o), 32'd1);
        checkOutput("idle_busy", 32'(busy_o), 32'd0);

        // Free run, period 5: 4 COMPUTE + 9 COPY + 5 HOLD + 1 IDLE between starts.
        clearLog();
        applyStimulus(1'b1, 1'b0, 8'd5, 1'b1);
        runUntilStarts("run_starts", 2, 100);
        if (start_cycles.size() >= 2) begin
            checkOutput("run_gap", 32'(start_cycles[1] - start_cycles[0]), 32'd19);
            checkOutput("run_busy", 32'(busy_cycles), 32'd14);
            checkOutput("run_draw_low", 32'(draw_low_cycles), 32'd14);
            if (wr_cycles.size() >= CELLS) begin
                checkOutput("first_wr_offset", 32'(wr_cycles[0] - start_cycles[0]), 32'd5);
                checkOutput("last_wr_offset", 32'(wr_cycles[CELLS-1] - start_cycles[0]), 32'd12);
            end
        end
        checkWrites("run");

        // Single step; a second step during COMPUTE is ignored.
        applyReset();
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'd2, 1'b1);
        runUntilStarts("step_first", 1, 20);
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 8'd2, 1'b1);
        repeat (40) stepCycle();
        checkOutput("step_starts", 32'(start_cycles.size()), 32'd1);
        checkOutput("step_wr_count", 32'(wr_addr_q.size()), 32'(CELLS));
        checkOutput("step_idle_busy", 32'(busy_o), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd2, 1'b0);
        stepCycle();
        checkOutput("idle_draw_off", 32'(draw_en_o), 32'd0);

        // run_i dropped mid-generation: finish it, then wait in IDLE.
        applyReset();
        applyStimulus(1'b1, 1'b0, 8'd2, 1'b1);
        runUntilStarts("runfall_first", 1, 20);
        applyStimulus(1'b0, 1'b0, 8'd2, 1'b1);
        repeat (40) stepCycle();
        checkOutput("runfall_starts", 32'(start_cycles.size()), 32'd1);
        checkOutput("runfall_wr_count", 32'(wr_addr_q.size()), 32'(CELLS));

        // Period 0 and 1 both hold one cycle.
        for (int p = 0; p < 2; p++) begin
            applyReset();
            applyStimulus(1'b1, 1'b0, TW'(p), 1'b1);
            runUntilStarts($sformatf("p%0d_starts", p), 2, 100);
            if (start_cycles.size() >= 2)
                checkOutput($sformatf("p%0d_gap", p), 32'(start_cycles[1] - start_cycles[0]), 32'd15);
        end

        // eng_done_i stuck high: only the start cycle ignores it, so COMPUTE lasts 2 cycles.
        applyReset();
        eng_always = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
        runUntilStarts("done_high_starts", 2, 100);
        if (start_cycles.size() >= 2)
            checkOutput("done_high_gap", 32'(start_cycles[1] - start_cycles[0]), 32'd13);
        eng_always = 1'b0;

        // Shortening the period in HOLD cycle 0 ends HOLD after 3 cycles.
        applyReset();
        applyStimulus(1'b1, 1'b0, 8'd50, 1'b1);
        runUntilStarts("midhold_first", 1, 20);
        begin
            int k;
            k = 0;
            while (busy_o && k < 40) begin
                stepCycle();
                k++;
            end
        end
        applyStimulus(1'b1, 1'b0, 8'd3, 1'b1);
        runUntilStarts("midhold_starts", 2, 100);
        if (start_cycles.size() >= 2)
            checkOutput("midhold_gap", 32'(start_cycles[1] - start_cycles[0]), 32'd17);

        // Reset after the 4th write aborts the copy; the next generation starts from address 0.
        applyReset();
        applyStimulus(1'b1, 1'b0, 8'd5, 1'b1);
        runUntilWrites(4, 60);
        checkOutput("abort_pre_writes", 32'(wr_addr_q.size()), 32'd4);
        reset_i = 1'b1;
        #1;
        checkOutput("abort_outputs", allOutputs(), 32'd0);
        stepCycle();
        stepCycle();
        checkOutput("abort_no_writes", 32'(wr_addr_q.size()), 32'd4);
        reset_i = 1'b0;
        clearLog();
        runUntilWrites(CELLS, 60);
        stepCycle();
        checkWrites("restart");

`ifdef SAND_FRAME_COUNTER_EN
        applyReset();
        checkOutput("frame_count_reset", 32'(frame_count_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'd1, 1'b1);
        runUntilStarts("frame_starts", 4, 200);
        checkOutput("frame_count", 32'(frame_count_o), 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/sand_frame_sequencer.md
SAND_FRAME_SEQUENCER -- requirements
Module: sand_frame_sequencer

Interface
REQ-001 SHALL have parameter ACTIVE_COLUMNS, default 640, grid width in cells.
REQ-002 SHALL have parameter ACTIVE_ROWS, default 480, grid height in cells.
REQ-003 SHALL have parameter DATA_WIDTH, default 1, bits per cell.
REQ-004 SHALL have parameter TICK_WIDTH, default 27, width of the hold-period counter.
REQ-005 SHALL have parameter ADDR_WIDTH, default $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS), cell address width.
REQ-006 SHALL have port clk_i, input, 1, clock; reset_i, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have port period_i, input, TICK_WIDTH, hold cycles per generation.
REQ-008 SHALL have port run_i, input, 1, free-run enable; step_i, input, 1, single-generation request.
REQ-009 SHALL have port draw_en_i, input, 1, user draw request; draw_en_o, output, 1, gated draw grant.
REQ-010 SHALL have port eng_start_o, output, 1, compute-engine start; eng_done_i, input, 1, compute-engine done.
REQ-011 SHALL have port ram_rd_address_o, output, ADDR_WIDTH; ram_rd_data_i, input, DATA_WIDTH, with 1-cycle read latency.
REQ-012 SHALL have port vram_wr_address_o, output, ADDR_WIDTH; vram_wr_data_o, output, DATA_WIDTH; vram_wr_en_o, output, 1.
REQ-013 SHALL have port busy_o, output, 1, high in COMPUTE and COPY.

Function
REQ-014 SHALL implement states IDLE, COMPUTE, COPY, HOLD.
REQ-015 IDLE: if run_i=1, or step_i=1 with run_i=0, SHALL go to COMPUTE next cycle.
REQ-016 SHALL assert eng_start_o for exactly the first COMPUTE cycle.
REQ-017 COMPUTE: SHALL ignore eng_done_i in the start cycle and go to COPY on the first later cycle with eng_done_i=1.
REQ-018 COPY: SHALL issue read addresses 0..N-1 on consecutive cycles, N=ACTIVE_COLUMNS*ACTIVE_ROWS.
REQ-019 COPY: SHALL write VRAM one cycle after each read, address a with data ram[a], so vram_wr_en_o is high exactly N cycles with addresses 0..N-1 ascending.
REQ-020 COPY SHALL last N+1 cycles, then go to HOLD with the hold counter at 0.
REQ-021 HOLD: SHALL count cycles and go to IDLE when count == max(period_i,1)-1; period_i=0 SHALL behave as 1.
REQ-022 SHALL sample period_i on every HOLD cycle; a change mid-HOLD SHALL take effect immediately.
REQ-023 SHALL assert draw_en_o = draw_en_i in IDLE and HOLD, and 0 in COMPUTE and COPY.
REQ-024 SHALL ignore step_i outside IDLE.
REQ-025 If run_i falls mid-generation, SHALL finish the generation and then wait in IDLE.
REQ-026 SHALL hold vram_wr_en_o and eng_start_o at 0 outside COPY and COMPUTE respectively.

Reset
REQ-027 Reset SHALL force IDLE, clear all counters, and drive every output to 0 (draw_en_o=0 while reset is high).
REQ-028 Reset mid-COPY SHALL abort the copy with no further VRAM writes; after release, the next generation SHALL restart from address 0.

Configuration
REQ-029 With macro SAND_FRAME_COUNTER_EN defined, SHALL add output frame_count_o, 16 bits, reset 0.
REQ-030 frame_count_o SHALL increment on the COPY-to-HOLD transition and wrap from 0xFFFF to 0.
REQ-031 Without SAND_FRAME_COUNTER_EN, port frame_count_o and its logic SHALL be absent.

Structure
REQ-032 State enum seq_state_t and default grid constants SHALL reside in shared package sand_pkg.
REQ-033 The copy pipeline (address counter, 1-cycle delay, done flag) SHALL be sub-module frame_copier.

Verification (ACTIVE_COLUMNS=4, ACTIVE_ROWS=2, N=8)
REQ-034 run_i=1, period_i=5, eng_done_i 3 cycles after start -> 8 writes to addresses 0..7 with data = preloaded ram[a]; 5 HOLD cycles; next eng_start_o pulse.
REQ-035 run_i=0, one step_i pulse -> exactly one generation; a second step_i pulse during COMPUTE -> ignored, stays in IDLE afterwards.
REQ-036 period_i=0 -> HOLD lasts 1 cycle.
REQ-037 draw_en_i held 1 -> draw_en_o=0 throughout COMPUTE and COPY, 1 in IDLE and HOLD.
REQ-038 reset_i pulsed after the 4th COPY write -> outputs 0 immediately; next generation writes addresses 0..7 in full.
REQ-039 With SAND_FRAME_COUNTER_EN defined, 3 generations -> frame_count_o=3.
